// File: rtl/ddr_burst_pkg.sv
// Shared types and constants for the DDR burst responder.
package ddr_burst_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRd,
        StFin,
        StGap
    } state_e;

    localparam logic [2:0]  APP_CMD_WR        = 3'b000;
    localparam logic [2:0]  APP_CMD_RD        = 3'b001;
    localparam int unsigned DEFAULT_ADDR_STEP = 8;

endpackage

// File: rtl/ddr_wr_fifo2.sv
// Two-entry write-beat FIFO; head is always visible on dout, storage clears on reset.
module ddr_wr_fifo2 #(
    parameter int unsigned WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             empty
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wptr_q, wptr_d;
    logic             rptr_q, rptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             do_push, do_pop;

    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign do_pop  = pop && (cnt_q != 2'd0);
    assign do_push = push && ((cnt_q != 2'd2) || do_pop);

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d        = ~wptr_q;
        end
        if (do_pop) begin
            rptr_d = ~rptr_q;
        end
        cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q  <= '{default: '0};
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
            cnt_q  <= 2'd0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign count = cnt_q;
    assign empty = (cnt_q == 2'd0);

endmodule

// File: rtl/ddr_burst_responder.sv
// Bridges one cache-side read/write burst at a time onto the DDR controller app port.
// Define DDR_BURST_STAT_EN to add burst/cycle/stall statistics outputs.
module ddr_burst_responder
    import ddr_burst_pkg::*;
#(
    parameter int unsigned DDR_DATA_WIDTH = 128,
    parameter int unsigned DDR_ADDR_WIDTH = 28,
    parameter int unsigned ADDR_STEP      = DEFAULT_ADDR_STEP
) (
    input  logic                        mem_clk,
    input  logic                        rst,
    input  logic                        rd_burst_req,
    input  logic                        wr_burst_req,
    input  logic [9:0]                  rd_burst_len,
    input  logic [9:0]                  wr_burst_len,
    input  logic [DDR_ADDR_WIDTH-1:0]   rd_burst_addr,
    input  logic [DDR_ADDR_WIDTH-1:0]   wr_burst_addr,
    output logic                        rd_burst_data_valid,
    output logic                        wr_burst_data_req,
    output logic [DDR_DATA_WIDTH-1:0]   rd_burst_data,
    input  logic [DDR_DATA_WIDTH-1:0]   wr_burst_data,
    output logic                        rd_burst_finish,
    output logic                        wr_burst_finish,
`ifdef DDR_BURST_STAT_EN
    output logic [31:0]                 burst_cnt,
    output logic [15:0]                 last_burst_cycles,
    output logic [31:0]                 stall_cycles,
`endif
    input  logic                        init_calib_complete,
    output logic [DDR_ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]                  app_cmd,
    output logic                        app_en,
    input  logic                        app_rdy,
    output logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
    output logic                        app_wdf_wren,
    output logic                        app_wdf_end,
    output logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
    input  logic                        app_wdf_rdy,
    input  logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
    input  logic                        app_rd_data_valid
);

    localparam logic [DDR_ADDR_WIDTH-1:0] STEP = DDR_ADDR_WIDTH'(ADDR_STEP);

    state_e                      state_q, state_d;
    logic [DDR_ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [9:0]                  len_q, len_d;
    logic [9:0]                  req_cnt_q, req_cnt_d;
    logic [9:0]                  done_cnt_q, done_cnt_d;
    logic                        is_wr_q, is_wr_d;
    logic                        pend_q, pend_d;
    logic [DDR_DATA_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                        rd_valid_q, rd_valid_d;

    logic [DDR_DATA_WIDTH-1:0]   fifo_dout;
    logic [1:0]                  fifo_cnt;
    logic                        fifo_empty;
    logic [1:0]                  occ;
    logic                        wr_beat_go;
    logic                        wr_req_go;
    logic                        rd_pending;
    logic                        rd_cmd_go;
    logic                        rd_beat_in;

    ddr_wr_fifo2 #(
        .WIDTH (DDR_DATA_WIDTH)
    ) u_wr_fifo (
        .clk   (mem_clk),
        .rst   (rst),
        .push  (pend_q),
        .pop   (wr_beat_go),
        .din   (wr_burst_data),
        .dout  (fifo_dout),
        .count (fifo_cnt),
        .empty (fifo_empty)
    );

    assign wr_beat_go = (state_q == StWr) && !fifo_empty && app_rdy && app_wdf_rdy;
    // Occupancy counts beats already requested but not yet pushed, net of this cycle's pop,
    // which is what lets the two-entry FIFO sustain one beat per cycle.
    assign occ        = fifo_cnt + 2'(pend_q) - 2'(wr_beat_go);
    assign wr_req_go  = (state_q == StWr) && (req_cnt_q < len_q) && (occ < 2'd2);
    assign rd_pending = (state_q == StRd) && (req_cnt_q < len_q);
    assign rd_cmd_go  = rd_pending && app_rdy;
    assign rd_beat_in = (state_q == StRd) && app_rd_data_valid;

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            len_q      <= '0;
            req_cnt_q  <= '0;
            done_cnt_q <= '0;
            is_wr_q    <= 1'b0;
            pend_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            req_cnt_q  <= req_cnt_d;
            done_cnt_q <= done_cnt_d;
            is_wr_q    <= is_wr_d;
            pend_q     <= pend_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        req_cnt_d  = req_cnt_q;
        done_cnt_d = done_cnt_q;
        is_wr_d    = is_wr_q;
        pend_d     = wr_req_go;
        rd_valid_d = rd_beat_in;
        rd_data_d  = rd_beat_in ? app_rd_data : rd_data_q;

        unique case (state_q)
            StIdle: begin
                req_cnt_d  = '0;
                done_cnt_d = '0;
                if (init_calib_complete && (wr_burst_req || rd_burst_req)) begin
                    is_wr_d = wr_burst_req;
                    addr_d  = wr_burst_req ? wr_burst_addr : rd_burst_addr;
                    len_d   = wr_burst_req ? wr_burst_len : rd_burst_len;
                    if (len_d == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = wr_burst_req ? StWr : StRd;
                    end
                end
            end
            StWr: begin
                if (wr_req_go) begin
                    req_cnt_d = req_cnt_q + 10'd1;
                end
                if (wr_beat_go) begin
                    addr_d     = addr_q + STEP;
                    done_cnt_d = done_cnt_q + 10'd1;
                end
                if (done_cnt_q == len_q) begin
                    state_d = StFin;
                end
            end
            StRd: begin
                if (rd_cmd_go) begin
                    req_cnt_d = req_cnt_q + 10'd1;
                    addr_d    = addr_q + STEP;
                end
                if (rd_beat_in) begin
                    done_cnt_d = done_cnt_q + 10'd1;
                end
                // Registered compare: the last beat is already on rd_burst_data this cycle.
                if (done_cnt_q == len_q) begin
                    state_d = StFin;
                end
            end
            StFin:   state_d = StGap;
            StGap:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        app_en            = 1'b0;
        app_cmd           = APP_CMD_WR;
        app_wdf_wren      = 1'b0;
        app_wdf_end       = 1'b0;
        wr_burst_data_req = 1'b0;
        rd_burst_finish   = 1'b0;
        wr_burst_finish   = 1'b0;
        unique case (state_q)
            StWr: begin
                app_en            = !fifo_empty;
                app_wdf_wren      = !fifo_empty;
                app_wdf_end       = !fifo_empty;
                wr_burst_data_req = wr_req_go;
            end
            StRd: begin
                app_en  = rd_pending;
                app_cmd = APP_CMD_RD;
            end
            StFin: begin
                wr_burst_finish = is_wr_q;
                rd_burst_finish = !is_wr_q;
            end
            default: ;
        endcase
    end

    assign app_addr            = addr_q;
    assign app_wdf_data        = fifo_dout;
    assign app_wdf_mask        = '0;
    assign rd_burst_data       = rd_data_q;
    assign rd_burst_data_valid = rd_valid_q;

`ifdef DDR_BURST_STAT_EN
    logic [31:0] burst_cnt_q, burst_cnt_d;
    logic [15:0] cur_cyc_q, cur_cyc_d;
    logic [15:0] last_cyc_q, last_cyc_d;
    logic [31:0] stall_q, stall_d;
    logic        active;

    assign active = (state_q == StWr) || (state_q == StRd);

    always_comb begin
        burst_cnt_d = burst_cnt_q + 32'(state_q == StFin);
        stall_d     = stall_q + 32'(active && !app_rdy);
        last_cyc_d  = (state_q == StFin) ? cur_cyc_q : last_cyc_q;
        cur_cyc_d   = cur_cyc_q;
        if (state_q == StIdle) begin
            cur_cyc_d = '0;
        end else if (active && (cur_cyc_q != '1)) begin
            cur_cyc_d = cur_cyc_q + 16'd1;
        end
    end

    always_ff @(posedge mem_clk or posedge rst) begin
        if (rst) begin
            burst_cnt_q <= '0;
            cur_cyc_q   <= '0;
            last_cyc_q  <= '0;
            stall_q     <= '0;
        end else begin
            burst_cnt_q <= burst_cnt_d;
            cur_cyc_q   <= cur_cyc_d;
            last_cyc_q  <= last_cyc_d;
            stall_q     <= stall_d;
        end
    end

    assign burst_cnt         = burst_cnt_q;
    assign last_burst_cycles = last_cyc_q;
    assign stall_cycles      = stall_q;
`endif

endmodule

// File: tb/tb_ddr_burst_responder.sv
// Self-checking bench for ddr_burst_responder: table of directed bursts, reset and
// calibration sequences, then randomized bursts checked against a transaction-level model.
module tb_ddr_burst_responder;

    localparam int DW = 128;
    localparam int AW = 28;

    logic          mem_clk;
    logic          rst;
    logic          rd_burst_req, wr_burst_req;
    logic [9:0]    rd_burst_len, wr_burst_len;
    logic [AW-1:0] rd_burst_addr, wr_burst_addr;
    logic          rd_burst_data_valid, wr_burst_data_req;
    logic [DW-1:0] rd_burst_data, wr_burst_data;
    logic          rd_burst_finish, wr_burst_finish;
    logic          init_calib_complete;
    logic [AW-1:0] app_addr;
    logic [2:0]    app_cmd;
    logic          app_en, app_rdy;
    logic [DW-1:0] app_wdf_data;
    logic          app_wdf_wren, app_wdf_end;
    logic [DW/8-1:0] app_wdf_mask;
    logic          app_wdf_rdy;
    logic [DW-1:0] app_rd_data;
    logic          app_rd_data_valid;
`ifdef DDR_BURST_STAT_EN
    logic [31:0]   burst_cnt, stall_cycles;
    logic [15:0]   last_burst_cycles;
`endif

    ddr_burst_responder dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .rd_burst_req        (rd_burst_req),
        .wr_burst_req        (wr_burst_req),
        .rd_burst_len        (rd_burst_len),
        .wr_burst_len        (wr_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .wr_burst_addr       (wr_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .wr_burst_data_req   (wr_burst_data_req),
        .rd_burst_data       (rd_burst_data),
        .wr_burst_data       (wr_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_finish     (wr_burst_finish),
`ifdef DDR_BURST_STAT_EN
        .burst_cnt           (burst_cnt),
        .last_burst_cycles   (last_burst_cycles),
        .stall_cycles        (stall_cycles),
`endif
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_mask        (app_wdf_mask),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        bit          is_wr;
        bit          both;
        logic [27:0] addr;
        int          len;
        int          mode;        // 0: rdy high, 1: wdf_rdy toggles, 2: random rdy
        int          calib_delay;
        int          exp_beats;
        logic [27:0] exp_last;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_w(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string name);
        check_w({name, ".ctrl"}, 128'({app_en, app_cmd, app_addr, app_wdf_wren, app_wdf_end,
                app_wdf_mask, wr_burst_data_req, rd_burst_data_valid, rd_burst_finish,
                wr_burst_finish}), '0);
        check_w({name, ".wdata"}, app_wdf_data, '0);
        check_w({name, ".rdata"}, rd_burst_data, '0);
    endtask

    // Runs one burst; expectations come from the burst's own rules: beat i sits at
    // start + 8*i (mod 2^28), write data leaves in supply order, read data is returned in order.
    task automatic run_burst(input string nm, input vec_t v);
        logic [127:0] wdata  [$];
        logic [27:0]  rd_q   [$];
        logic [127:0] exp_rd [$];
        logic [127:0] rdat;
        logic [27:0]  h_addr, last_addr;
        logic [127:0] h_data;
        int beats, rd_got, dreqs, fins, bad, stable_bad, spurious, post_bad, early;
        int sup, cyc, gap, fin_cyc, got_at_fin, first_act, first_acc, last_acc;
        bit dreq_prev, held, timeout, wrong_fin, fin_rdv, active;
        beats = 0; rd_got = 0; dreqs = 0; fins = 0; bad = 0; stable_bad = 0;
        spurious = 0; post_bad = 0; early = 0; sup = 0; cyc = 0; gap = 0;
        fin_cyc = -1; got_at_fin = -1; first_act = -1; first_acc = -1; last_acc = -1;
        dreq_prev = 0; held = 0; timeout = 0; wrong_fin = 0; fin_rdv = 0;
        last_addr = '0; h_addr = '0; h_data = '0;
        for (int i = 0; i < v.len; i++) wdata.push_back({$urandom, $urandom, $urandom, $urandom});
        while (1) begin
            @(posedge mem_clk);
            #1;
            active = (fin_cyc < 0) || (cyc <= fin_cyc + 1);
            init_calib_complete = (cyc >= v.calib_delay);
            wr_burst_req  = v.is_wr && active;
            rd_burst_req  = active && (!v.is_wr || (v.both && cyc <= v.calib_delay));
            wr_burst_addr = v.addr;
            rd_burst_addr = v.addr;
            wr_burst_len  = 10'(v.len);
            rd_burst_len  = 10'(v.len);
            if (dreq_prev && sup < v.len) begin
                wr_burst_data = wdata[sup];
                sup++;
            end else begin
                wr_burst_data = {$urandom, $urandom, $urandom, $urandom};
            end
            case (v.mode)
                0:       begin app_rdy = 1'b1; app_wdf_rdy = 1'b1; end
                1:       begin app_rdy = 1'b1; app_wdf_rdy = (cyc % 2 == 1); end
                default: begin
                    app_rdy     = ($urandom_range(0, 3) != 0);
                    app_wdf_rdy = ($urandom_range(0, 2) != 0);
                end
            endcase
            app_rd_data = {$urandom, $urandom, $urandom, $urandom};
            app_rd_data_valid = 1'b0;
            if (v.is_wr) begin
                app_rd_data_valid = ($urandom_range(0, 4) == 0);
            end else if (gap > 0) begin
                gap--;
            end else if (rd_q.size() > 0) begin
                void'(rd_q.pop_front());
                app_rd_data_valid = 1'b1;
                exp_rd.push_back(app_rd_data);
                gap = $urandom_range(0, 3);
            end

            @(negedge mem_clk);
            if ((app_en || wr_burst_data_req) && first_act < 0) first_act = cyc;
            if (cyc <= v.calib_delay && (app_en || wr_burst_data_req)) early++;
            if (app_en) begin
                if (held && (app_addr !== h_addr || (v.is_wr && app_wdf_data !== h_data)))
                    stable_bad++;
                if (v.is_wr) begin
                    if (app_cmd !== 3'b000 || !app_wdf_wren || !app_wdf_end) bad++;
                    if (app_rdy && app_wdf_rdy) begin
                        if (beats >= v.len) bad++;
                        else if (app_addr !== 28'(v.addr + 28'(8 * beats)) ||
                                 app_wdf_data !== wdata[beats]) bad++;
                        last_addr = app_addr;
                        if (first_acc < 0) first_acc = cyc;
                        last_acc = cyc;
                        beats++;
                        held = 0;
                    end else begin
                        held = 1; h_addr = app_addr; h_data = app_wdf_data;
                    end
                end else begin
                    if (app_cmd !== 3'b001) bad++;
                    if (app_rdy) begin
                        if (beats >= v.len || app_addr !== 28'(v.addr + 28'(8 * beats))) bad++;
                        rd_q.push_back(app_addr);
                        last_addr = app_addr;
                        beats++;
                        held = 0;
                    end else begin
                        held = 1; h_addr = app_addr;
                    end
                end
            end else if (held) begin
                stable_bad++;
                held = 0;
            end
            if (wr_burst_data_req) dreqs++;
            dreq_prev = wr_burst_data_req;
            if (rd_burst_data_valid) begin
                if (v.is_wr || exp_rd.size() == 0) spurious++;
                else begin
                    rdat = exp_rd.pop_front();
                    if (rd_burst_data !== rdat) bad++;
                    rd_got++;
                end
            end
            if (rd_burst_finish || wr_burst_finish) begin
                fins++;
                if (wr_burst_finish !== v.is_wr || rd_burst_finish !== !v.is_wr) wrong_fin = 1;
                if (rd_burst_data_valid) fin_rdv = 1;
                if (fin_cyc < 0) begin
                    fin_cyc = cyc;
                    got_at_fin = v.is_wr ? beats : rd_got;
                end
            end
            if (fin_cyc >= 0 && cyc > fin_cyc && app_en) post_bad++;
            cyc++;
            if (fin_cyc >= 0 && cyc >= fin_cyc + 5) break;
            if (cyc > 4000) begin
                timeout = 1;
                break;
            end
        end
        check({nm, ".timeout"}, int'(timeout), 0);
        check({nm, ".beats"}, beats, v.exp_beats);
        if (v.exp_beats > 0) check_w({nm, ".last_addr"}, 128'(last_addr), 128'(v.exp_last));
        check({nm, ".model_errs"}, bad, 0);
        check({nm, ".stall_stable"}, stable_bad, 0);
        check({nm, ".fin_pulses"}, fins, 1);
        check({nm, ".fin_dir"}, int'(wrong_fin), 0);
        check({nm, ".beats_at_fin"}, got_at_fin, v.exp_beats);
        check({nm, ".fin_with_rdv"}, int'(fin_rdv), 0);
        check({nm, ".spurious_rdv"}, spurious, 0);
        check({nm, ".post_fin_en"}, post_bad, 0);
        check({nm, ".early"}, early, 0);
        if (v.is_wr) check({nm, ".data_reqs"}, dreqs, v.len);
        if (v.len > 0) check({nm, ".first_act_cyc"}, first_act, v.calib_delay + 1);
        if (v.is_wr && v.mode == 0 && v.len > 1)
            check({nm, ".throughput"}, last_acc - first_acc, v.len - 1);
    endtask

    initial begin
        vec_t vecs [8];
        vec_t rv;
        int   seen_en;
        int   rst_fins;

        rst = 1'b1;
        rd_burst_req = 0; wr_burst_req = 0; rd_burst_len = '0; wr_burst_len = '0;
        rd_burst_addr = '0; wr_burst_addr = '0; wr_burst_data = '0;
        init_calib_complete = 0; app_rdy = 0; app_wdf_rdy = 0;
        app_rd_data = '0; app_rd_data_valid = 0;

        vecs[0] = '{1'b1, 1'b0, 28'h0008000, 4,   0, 0,  4,   28'h0008018};
        vecs[1] = '{1'b0, 1'b0, 28'h0010000, 17,  0, 0,  17,  28'h0010080};
        vecs[2] = '{1'b1, 1'b0, 28'h0100000, 128, 1, 0,  128, 28'h01003F8};
        vecs[3] = '{1'b1, 1'b1, 28'h0200040, 3,   0, 10, 3,   28'h0200050};
        vecs[4] = '{1'b1, 1'b0, 28'h0000100, 0,   0, 0,  0,   28'h0000000};
        vecs[5] = '{1'b1, 1'b0, 28'hFFFFFF8, 2,   0, 0,  2,   28'h0000000};
        vecs[6] = '{1'b0, 1'b0, 28'hFFFFFF0, 3,   2, 0,  3,   28'h0000000};
        vecs[7] = '{1'b0, 1'b0, 28'h1234560, 0,   0, 0,  0,   28'h0000000};

        repeat (3) @(posedge mem_clk);
        @(negedge mem_clk);
        check_zero("reset");
        @(posedge mem_clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 8; i++) run_burst($sformatf("vec%0d", i), vecs[i]);

        // Reset in the middle of a read abandons it without a finish pulse.
        @(posedge mem_clk);
        #1;
        init_calib_complete = 1; rd_burst_addr = 28'h0123400; rd_burst_len = 10'd20;
        rd_burst_req = 1; app_rdy = 1; app_wdf_rdy = 1; app_rd_data_valid = 0;
        seen_en = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge mem_clk);
            if (app_en) seen_en++;
            @(posedge mem_clk);
            #1;
        end
        check("rst_mid.reads_issued", seen_en, 3);
        rst = 1'b1; rd_burst_req = 0; app_rd_data_valid = 1;
        #1;
        check_zero("rst_mid.async");
        rst_fins = 0;
        repeat (2) begin
            @(negedge mem_clk);
            if (rd_burst_finish || wr_burst_finish) rst_fins++;
        end
        check_zero("rst_mid.held");
        @(posedge mem_clk);
        #1;
        rst = 1'b0; app_rd_data_valid = 0;
        repeat (3) begin
            @(negedge mem_clk);
            if (rd_burst_finish || wr_burst_finish || rd_burst_data_valid) rst_fins++;
        end
        check("rst_mid.no_finish", rst_fins, 0);
        rv = '{1'b0, 1'b0, 28'h0000400, 1, 0, 0, 1, 28'h0000400};
        run_burst("post_rst_rd1", rv);

        for (int i = 0; i < 24; i++) begin
            rv.is_wr       = 1'($urandom_range(0, 1));
            rv.both        = 1'b0;
            rv.addr        = 28'($urandom);
            rv.len         = $urandom_range(1, 40);
            rv.mode        = 2;
            rv.calib_delay = 0;
            rv.exp_beats   = rv.len;
            rv.exp_last    = 28'(rv.addr + 28'(8 * (rv.len - 1)));
            run_burst($sformatf("rnd%0d", i), rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ddr_burst_responder.md
# ddr_burst_responder

Controller-side end of the burst request interface used by the DDR/cache interface block. Accepts one read or write burst at a time (`rd_burst_req`/`wr_burst_req` with address and length), paces write data with `wr_burst_data_req`, and returns read data with `rd_burst_data_valid`. Drives the DDR memory-controller application port (command, write-data and read-data channels) beat by beat, and pulses `rd_burst_finish`/`wr_burst_finish` when a burst completes.

## Interface
- `DDR_DATA_WIDTH`, 128, beat width on both sides
- `DDR_ADDR_WIDTH`, 28, burst/app address width
- `ADDR_STEP`, 8, app address increment per beat
- `mem_clk`  in  1  single clock for all logic
- `rst`  in  1  reset; asynchronous, active-high
- `rd_burst_req`, `wr_burst_req`  in  1  burst requests, held high until finish
- `rd_burst_len`, `wr_burst_len`  in  10  beats in burst
- `rd_burst_addr`, `wr_burst_addr`  in  DDR_ADDR_WIDTH  start address
- `wr_burst_data`  in  DDR_DATA_WIDTH  write beat, valid the cycle after a `wr_burst_data_req` edge
- `wr_burst_data_req`  out  1  request one write beat
- `rd_burst_data`  out  DDR_DATA_WIDTH  read beat
- `rd_burst_data_valid`  out  1  read beat valid
- `rd_burst_finish`, `wr_burst_finish`  out  1  one-cycle completion pulses
- `init_calib_complete`  in  1  controller calibrated
- `app_addr`  out  DDR_ADDR_WIDTH; `app_cmd`  out  3 (000 write, 001 read); `app_en`  out  1; `app_rdy`  in  1
- `app_wdf_data`  out  DDR_DATA_WIDTH; `app_wdf_wren`, `app_wdf_end`  out  1; `app_wdf_mask`  out  DDR_DATA_WIDTH/8 (constant 0); `app_wdf_rdy`  in  1
- `app_rd_data`  in  DDR_DATA_WIDTH; `app_rd_data_valid`  in  1

## Operation
- States: IDLE, WR, RD, FIN, GAP.
- IDLE: waits for `init_calib_complete`=1. `wr_burst_req` wins over `rd_burst_req` when both are high. Latches addr/len and clears counters (`req_cnt`, `done_cnt`, 10 bit). Latched len 0 goes directly to FIN.
- WR:
  - `wr_burst_data_req`=1 when `req_cnt`<len and write-FIFO occupancy plus outstanding requests < 2. Each request increments `req_cnt`.
  - `wr_burst_data` is pushed into a 2-entry FIFO on the cycle after each request.
  - When the FIFO is non-empty, `app_rdy`=1 and `app_wdf_rdy`=1: `app_en`, `app_wdf_wren` and `app_wdf_end` are 1, `app_cmd`=000, the FIFO pops, the address advances by ADDR_STEP and `done_cnt` increments.
  - `done_cnt`==len goes to FIN.
- RD:
  - `app_en`=1 with `app_cmd`=001 while `req_cnt`<len. Accepted when `app_rdy`=1; the address then advances by ADDR_STEP.
  - Each `app_rd_data_valid` increments `done_cnt`.
  - `done_cnt`==len, with the last beat already presented, goes to FIN.
- FIN: the finish pulse for the active direction is high for exactly one cycle, then GAP.
- GAP: one idle cycle so a request still high at the finish edge is never restarted; then IDLE.
- Address arithmetic is modulo 2^DDR_ADDR_WIDTH, so it wraps silently. Latched len is 10 bit (max 1023).
- `app_rd_data_valid` outside RD is ignored and not forwarded.

## Timing
- Reset values: every output is 0; state IDLE; FIFO empty; counters 0.
- Reset mid-burst abandons the burst. No finish pulse is produced.
- IDLE→WR/RD takes 1 cycle after request sampled. The first `app_en` or `wr_burst_data_req` comes in the next cycle.
- `app_en`, `app_addr` and `app_wdf_*` come from registered state and FIFO head only. They have no combinational path from `app_rdy`/`app_wdf_rdy`.
- Read return: `rd_burst_data`/`rd_burst_data_valid` are registered copies of `app_rd_data`/`app_rd_data_valid`, 1-cycle latency.
- A finish pulse never coincides with `rd_burst_data_valid`. The pulse is at least 1 cycle after the last valid beat.
- Write throughput: 1 beat/cycle sustained when `app_rdy` and `app_wdf_rdy` are held high.
- `app_rdy` or `app_wdf_rdy` low stalls: outputs are held stable and no beat is lost or duplicated.

## Configuration
- `DDR_BURST_STAT_EN` defined adds three outputs:
  - `burst_cnt` (32): number of completed bursts.
  - `last_burst_cycles` (16): cycles from leaving IDLE to FIN, saturating.
  - `stall_cycles` (32): cycles spent in WR/RD with `app_rdy`=0.
  - All three reset to 0.
- Undefined: these ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Package `ddr_burst_pkg`: state enum, `APP_CMD_WR`=3'b000, `APP_CMD_RD`=3'b001, `ADDR_STEP` default.
- Sub-module `ddr_wr_fifo2`: 2-entry write-beat FIFO with push, pop, occupancy, and async active-high reset.

## Test plan
- Write len 4, addr 0x0008000, both rdy high → four `app_en` beats at 0x8000/8008/8010/8018 with data in request order; single `wr_burst_finish`; no further `app_en` while `wr_burst_req` is still high in GAP.
- Read len 17, `app_rd_data_valid` in gaps of 0–3 cycles → 17 `rd_burst_data_valid` beats with matching data, then `rd_burst_finish` ≥1 cycle after the last beat.
- `app_wdf_rdy` toggled every other cycle during a write of len 128 → exactly 128 writes, no drop or duplicate; `app_wdf_data` stable while stalled.
- `rd_burst_req` and `wr_burst_req` rise together; `init_calib_complete` held low for 10 cycles → nothing issued until calibration, then the write runs first.
- Len 0 write, and a burst starting at addr 0xFFFFFF8 → immediate finish; address wraps to 0x0000000 on the second beat.
- `rst` asserted mid-read → all outputs 0 next edge, no finish pulse; a following read of len 1 completes normally.
